// File: rtl/word_store_unit_pkg.sv
// Shared definitions for the word store unit: FSM state encoding and byte geometry.
// Byte selection lives here so the write sequencing never deals with bit slices directly.
package word_store_unit_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned WORD_W = 2 * BYTE_W;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FIRST  = 2'd1,
      ST_SECOND = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   function automatic logic [BYTE_W-1:0] pick_byte(input logic [WORD_W-1:0] word,
                                                   input logic              upper);
      return upper ? word[WORD_W-1:BYTE_W] : word[BYTE_W-1:0];
   endfunction

endpackage

// File: rtl/word_store_unit.sv
// Serialises a 16-bit word into two byte writes on a byte-wide memory port.
// Moore FSM; every output is a flop loaded from the decode of the next state.
module word_store_unit
   import word_store_unit_pkg::*;
#(
   parameter int unsigned N          = 16,
   parameter int unsigned AW         = 8,
   parameter bit          BIG_ENDIAN = 1'b0
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Start,
   input  logic [N-1:0]      WordIn,
   input  logic [AW-1:0]     AddrIn,
   input  logic              MemReady,
   output logic              MemWrite,
   output logic [AW-1:0]     MemAddr,
   output logic [BYTE_W-1:0] MemData,
   output logic              Busy,
   output logic              Done
);

   state_e              state_q, state_d;
   logic [N-1:0]        wreg_q, wreg_d;
   logic [AW-1:0]       areg_q, areg_d;

   logic                mem_write_q, mem_write_d;
   logic [AW-1:0]       mem_addr_q, mem_addr_d;
   logic [BYTE_W-1:0]   mem_data_q, mem_data_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   always_comb begin
      state_d = state_q;
      wreg_d  = wreg_q;
      areg_d  = areg_q;
      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               wreg_d  = WordIn;
               areg_d  = AddrIn;
               state_d = ST_FIRST;
            end
         end
         ST_FIRST: begin
            if (MemReady) state_d = ST_SECOND;
         end
         ST_SECOND: begin
            if (MemReady) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so the registered copies line up with state_q.
   always_comb begin
      mem_write_d = 1'b0;
      mem_addr_d  = '0;
      mem_data_d  = '0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      case (state_d)
         ST_FIRST: begin
            mem_write_d = 1'b1;
            mem_addr_d  = areg_d;
            mem_data_d  = pick_byte(wreg_d, BIG_ENDIAN);
            busy_d      = 1'b1;
         end
         ST_SECOND: begin
            mem_write_d = 1'b1;
            mem_addr_d  = areg_d + AW'(1);
            mem_data_d  = pick_byte(wreg_d, !BIG_ENDIAN);
            busy_d      = 1'b1;
         end
         ST_DONE: begin
            busy_d      = 1'b1;
            done_d      = 1'b1;
         end
         default: begin
            mem_write_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q     <= ST_IDLE;
         wreg_q      <= '0;
         areg_q      <= '0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_data_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wreg_q      <= wreg_d;
         areg_q      <= areg_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_data_q  <= mem_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign MemWrite = mem_write_q;
   assign MemAddr  = mem_addr_q;
   assign MemData  = mem_data_q;
   assign Busy     = busy_q;
   assign Done     = done_q;

endmodule
